// File: rtl/bram_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_load_sequencer
//  Description : Fills the input-matrix BRAM and the weight-matrix BRAM from
//                two ready/valid word streams, pairing consecutive words so
//                that both true-dual-port write ports are used every second
//                accepted word, then pulses write_phase_done to hand off to
//                the read/compute phase.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_load_sequencer #(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 32,
    parameter int ADDR_WIDTH_A = 4,
    parameter int ADDR_WIDTH_B = 4,
    parameter int NUM_A_WORDS  = 9,
    parameter int NUM_B_WORDS  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,

    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [DATA_WIDTH_A-1:0] a_data,

    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH_B-1:0] w_data,

    output logic                    in_mat_ena,
    output logic                    in_mat_wea,
    output logic [ADDR_WIDTH_A-1:0] in_mat_wr_addra,
    output logic [DATA_WIDTH_A-1:0] in_mat_dina,
    output logic                    in_mat_enb,
    output logic                    in_mat_web,
    output logic [ADDR_WIDTH_A-1:0] in_mat_wr_addrb,
    output logic [DATA_WIDTH_A-1:0] in_mat_dinb,

    output logic                    w_mat_ena,
    output logic                    w_mat_wea,
    output logic [ADDR_WIDTH_B-1:0] w_mat_wr_addra,
    output logic [DATA_WIDTH_B-1:0] w_mat_dina,
    output logic                    w_mat_enb,
    output logic                    w_mat_web,
    output logic [ADDR_WIDTH_B-1:0] w_mat_wr_addrb,
    output logic [DATA_WIDTH_B-1:0] w_mat_dinb,

    output logic                    write_phase_done,
    output logic                    busy
);

    // One word counter is shared by both load phases, so it is sized for the wider address.
    localparam int CNT_W = (ADDR_WIDTH_A > ADDR_WIDTH_B) ? ADDR_WIDTH_A : ADDR_WIDTH_B;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD_IN = 3'd1;
    localparam logic [2:0] c_LOAD_W  = 3'd2;
    localparam logic [2:0] c_FLUSH   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST_A  = CNT_W'(NUM_A_WORDS - 1);
    localparam logic [CNT_W-1:0] c_LAST_B  = CNT_W'(NUM_B_WORDS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_prev;
    logic                    r_pending;
    logic [DATA_WIDTH_A-1:0] r_hold_a;
    logic [DATA_WIDTH_B-1:0] r_hold_w;
    logic                    r_phase_done;
    logic                    w_a_fire;
    logic                    w_w_fire;
    logic                    w_a_last;
    logic                    w_w_last;
    logic                    w_start;

    // A handshake can only complete while the matching phase owns its stream.
    assign w_a_fire   = a_valid && (r_state == c_LOAD_IN);
    assign w_w_fire   = w_valid && (r_state == c_LOAD_W);
    assign w_a_last   = w_a_fire && (r_cnt == c_LAST_A);
    assign w_w_last   = w_w_fire && (r_cnt == c_LAST_B);
    assign w_start    = load_start && ((r_state == c_IDLE) || (r_state == c_DONE));
    // The held word of a pair always sits one address below the current word.
    assign w_cnt_prev = r_cnt - c_CNT_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: load_start is honoured only from IDLE or DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (w_start)  w_next_state = c_LOAD_IN;
            c_LOAD_IN:      if (w_a_last) w_next_state = c_LOAD_W;
            c_LOAD_W:       if (w_w_last) w_next_state = c_FLUSH;
            c_FLUSH:                      w_next_state = c_DONE;
            default:                      w_next_state = c_IDLE;
        endcase
    end

    // State-decoded stream readiness and busy indication.
    always_comb begin
        a_ready = (r_state == c_LOAD_IN);
        w_ready = (r_state == c_LOAD_W);
        busy    = (r_state == c_LOAD_IN) || (r_state == c_LOAD_W) || (r_state == c_FLUSH);
    end

    assign write_phase_done = r_phase_done;

    // Word counting, pair holding and registered BRAM write ports; enables are single-cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_pending       <= 1'b0;
            r_hold_a        <= '0;
            r_hold_w        <= '0;
            r_phase_done    <= 1'b0;
            in_mat_ena      <= 1'b0;
            in_mat_wea      <= 1'b0;
            in_mat_wr_addra <= '0;
            in_mat_dina     <= '0;
            in_mat_enb      <= 1'b0;
            in_mat_web      <= 1'b0;
            in_mat_wr_addrb <= '0;
            in_mat_dinb     <= '0;
            w_mat_ena       <= 1'b0;
            w_mat_wea       <= 1'b0;
            w_mat_wr_addra  <= '0;
            w_mat_dina      <= '0;
            w_mat_enb       <= 1'b0;
            w_mat_web       <= 1'b0;
            w_mat_wr_addrb  <= '0;
            w_mat_dinb      <= '0;
        end else begin
            in_mat_ena   <= 1'b0;
            in_mat_wea   <= 1'b0;
            in_mat_enb   <= 1'b0;
            in_mat_web   <= 1'b0;
            w_mat_ena    <= 1'b0;
            w_mat_wea    <= 1'b0;
            w_mat_enb    <= 1'b0;
            w_mat_web    <= 1'b0;
            r_phase_done <= (r_state == c_FLUSH);

            if (w_start) begin
                r_cnt     <= '0;
                r_pending <= 1'b0;
            end else if (w_a_fire) begin
                if (r_pending) begin
                    in_mat_ena      <= 1'b1;
                    in_mat_wea      <= 1'b1;
                    in_mat_wr_addra <= w_cnt_prev[ADDR_WIDTH_A-1:0];
                    in_mat_dina     <= r_hold_a;
                    in_mat_enb      <= 1'b1;
                    in_mat_web      <= 1'b1;
                    in_mat_wr_addrb <= r_cnt[ADDR_WIDTH_A-1:0];
                    in_mat_dinb     <= a_data;
                    r_pending       <= 1'b0;
                end else if (w_a_last) begin
                    // Odd word count: the unpaired tail goes out on port A alone.
                    in_mat_ena      <= 1'b1;
                    in_mat_wea      <= 1'b1;
                    in_mat_wr_addra <= r_cnt[ADDR_WIDTH_A-1:0];
                    in_mat_dina     <= a_data;
                end else begin
                    r_hold_a  <= a_data;
                    r_pending <= 1'b1;
                end
                r_cnt <= w_a_last ? '0 : (r_cnt + c_CNT_ONE);
            end else if (w_w_fire) begin
                if (r_pending) begin
                    w_mat_ena      <= 1'b1;
                    w_mat_wea      <= 1'b1;
                    w_mat_wr_addra <= w_cnt_prev[ADDR_WIDTH_B-1:0];
                    w_mat_dina     <= r_hold_w;
                    w_mat_enb      <= 1'b1;
                    w_mat_web      <= 1'b1;
                    w_mat_wr_addrb <= r_cnt[ADDR_WIDTH_B-1:0];
                    w_mat_dinb     <= w_data;
                    r_pending      <= 1'b0;
                end else if (w_w_last) begin
                    w_mat_ena      <= 1'b1;
                    w_mat_wea      <= 1'b1;
                    w_mat_wr_addra <= r_cnt[ADDR_WIDTH_B-1:0];
                    w_mat_dina     <= w_data;
                end else begin
                    r_hold_w  <= w_data;
                    r_pending <= 1'b1;
                end
                r_cnt <= w_w_last ? '0 : (r_cnt + c_CNT_ONE);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_load_sequencer
//  Description : Scoreboard bench for bram_load_sequencer (default build plus
//                a single-word input-matrix build).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_load_sequencer;

    localparam int NA = 9;
    localparam int NB = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] a_data = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] w_data = '0;
    logic        in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web;
    logic [3:0]  in_mat_wr_addra, in_mat_wr_addrb;
    logic [15:0] in_mat_dina, in_mat_dinb;
    logic        w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web;
    logic [3:0]  w_mat_wr_addra, w_mat_wr_addrb;
    logic [31:0] w_mat_dina, w_mat_dinb;
    logic        write_phase_done, busy;

    // second build: one input-matrix word, two weight words
    logic        u1_load_start = 1'b0;
    logic        u1_a_valid = 1'b0;
    logic        u1_a_ready;
    logic [15:0] u1_a_data = '0;
    logic        u1_w_valid = 1'b0;
    logic        u1_w_ready;
    logic [31:0] u1_w_data = '0;
    logic        u1_in_ena, u1_in_wea, u1_in_enb, u1_in_web;
    logic [3:0]  u1_in_addra, u1_in_addrb;
    logic [15:0] u1_in_dina, u1_in_dinb;
    logic        u1_w_ena, u1_w_wea, u1_w_enb, u1_w_web;
    logic [3:0]  u1_w_addra, u1_w_addrb;
    logic [31:0] u1_w_dina, u1_w_dinb;
    logic        u1_done, u1_busy;

    bram_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .in_mat_ena(in_mat_ena), .in_mat_wea(in_mat_wea),
        .in_mat_wr_addra(in_mat_wr_addra), .in_mat_dina(in_mat_dina),
        .in_mat_enb(in_mat_enb), .in_mat_web(in_mat_web),
        .in_mat_wr_addrb(in_mat_wr_addrb), .in_mat_dinb(in_mat_dinb),
        .w_mat_ena(w_mat_ena), .w_mat_wea(w_mat_wea),
        .w_mat_wr_addra(w_mat_wr_addra), .w_mat_dina(w_mat_dina),
        .w_mat_enb(w_mat_enb), .w_mat_web(w_mat_web),
        .w_mat_wr_addrb(w_mat_wr_addrb), .w_mat_dinb(w_mat_dinb),
        .write_phase_done(write_phase_done), .busy(busy)
    );

    bram_load_sequencer #(.NUM_A_WORDS(1), .NUM_B_WORDS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_start(u1_load_start),
        .a_valid(u1_a_valid), .a_ready(u1_a_ready), .a_data(u1_a_data),
        .w_valid(u1_w_valid), .w_ready(u1_w_ready), .w_data(u1_w_data),
        .in_mat_ena(u1_in_ena), .in_mat_wea(u1_in_wea),
        .in_mat_wr_addra(u1_in_addra), .in_mat_dina(u1_in_dina),
        .in_mat_enb(u1_in_enb), .in_mat_web(u1_in_web),
        .in_mat_wr_addrb(u1_in_addrb), .in_mat_dinb(u1_in_dinb),
        .w_mat_ena(u1_w_ena), .w_mat_wea(u1_w_wea),
        .w_mat_wr_addra(u1_w_addra), .w_mat_dina(u1_w_dina),
        .w_mat_enb(u1_w_enb), .w_mat_web(u1_w_web),
        .w_mat_wr_addrb(u1_w_addrb), .w_mat_dinb(u1_w_dinb),
        .write_phase_done(u1_done), .busy(u1_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int en;
        int addra;
        int dina;
        int addrb;
        int dinb;
    } wr_t;

    wr_t qa[$];
    wr_t qw[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ma = 0, mw = 0;
    int sw_cyc = -1, exp_wpd = -1, start_cyc = 0, last_wpd_cyc = 0, wpd_cnt = 0;
    bit active = 1'b0;
    bit gaps   = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compares writes present now, then records handshakes about to complete.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            qa.delete();
            qw.delete();
            ma = 0; mw = 0; active = 1'b0; sw_cyc = -1; exp_wpd = -1;
        end else begin
            if (in_mat_ena || in_mat_enb || in_mat_wea || in_mat_web) begin
                if (qa.size() == 0) begin
                    check("in_spurious_write", 128'(cyc), 128'(0));
                end else begin
                    e = qa.pop_front();
                    check("in_cycle", 128'(cyc), 128'(e.cyc));
                    check("in_en", {in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web}, 128'(e.en));
                    check("in_addra", in_mat_wr_addra, 128'(e.addra));
                    check("in_dina", in_mat_dina, 128'(e.dina));
                    if (e.en[1]) begin
                        check("in_addrb", in_mat_wr_addrb, 128'(e.addrb));
                        check("in_dinb", in_mat_dinb, 128'(e.dinb));
                    end
                end
            end
            if (w_mat_ena || w_mat_enb || w_mat_wea || w_mat_web) begin
                if (qw.size() == 0) begin
                    check("w_spurious_write", 128'(cyc), 128'(0));
                end else begin
                    e = qw.pop_front();
                    check("w_cycle", 128'(cyc), 128'(e.cyc));
                    check("w_en", {w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web}, 128'(e.en));
                    check("w_addra", w_mat_wr_addra, 128'(e.addra));
                    check("w_dina", w_mat_dina, 128'(e.dina));
                    if (e.en[1]) begin
                        check("w_addrb", w_mat_wr_addrb, 128'(e.addrb));
                        check("w_dinb", w_mat_dinb, 128'(e.dinb));
                    end
                end
            end
            if (write_phase_done) begin
                check("wpd_cycle", 128'(cyc), 128'(exp_wpd));
                wpd_cnt++;
                last_wpd_cyc = cyc;
                exp_wpd = -1;
                active = 1'b0;
            end
            if (cyc == sw_cyc) check("stream_switch", {a_ready, w_ready}, 128'(2'b01));

            if (load_start && !active) begin
                active = 1'b1; ma = 0; mw = 0; start_cyc = cyc;
            end
            if (a_valid && a_ready) begin
                e.cyc = cyc + 1; e.addrb = ma; e.dinb = ma;
                if (ma % 2 == 1) begin
                    e.en = 4'b1111; e.addra = ma - 1; e.dina = ma - 1; qa.push_back(e);
                end else if (ma == NA - 1) begin
                    e.en = 4'b1100; e.addra = ma; e.dina = ma; qa.push_back(e);
                end
                ma++;
                if (ma == NA) sw_cyc = cyc + 1;
            end
            if (w_valid && w_ready) begin
                e.cyc = cyc + 1; e.addrb = mw; e.dinb = 100 + mw;
                if (mw % 2 == 1) begin
                    e.en = 4'b1111; e.addra = mw - 1; e.dina = 99 + mw; qw.push_back(e);
                end else if (mw == NB - 1) begin
                    e.en = 4'b1100; e.addra = mw; e.dina = 100 + mw; qw.push_back(e);
                end
                mw++;
                if (mw == NB) exp_wpd = cyc + 2;
            end
        end
    end

    // Advance one clock and present the next stream words (index = words accepted so far).
    task automatic step();
        @(posedge clk);
        #1;
        a_valid = (ma < NA) && (!gaps || ($urandom_range(0, 3) != 0));
        a_data  = 16'(ma);
        w_valid = (mw < NB) && (!gaps || ($urandom_range(0, 3) != 0));
        w_data  = 32'(100 + mw);
    endtask

    task automatic do_load(input bit g, input bit inject, output int lat);
        int  base;
        bit  injected;
        base     = wpd_cnt;
        injected = 1'b0;
        gaps     = g;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 400 && wpd_cnt == base; i++) begin
            if (inject && !injected && mw == 5) begin
                load_start = 1'b1;
                injected   = 1'b1;
            end else begin
                load_start = 1'b0;
            end
            step();
        end
        load_start = 1'b0;
        if (wpd_cnt == base) check("load_timeout", 128'(0), 128'(1));
        lat = last_wpd_cyc - start_cyc;
        step();
        step();
        check("in_queue_drained", 128'(qa.size()), 128'(0));
        check("w_queue_drained", 128'(qw.size()), 128'(0));
        check("single_done_pulse", 128'(wpd_cnt - base), 128'(1));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        step(); step(); step();
        @(negedge clk);
        check("reset_in_ports", {in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web,
              in_mat_wr_addra, in_mat_wr_addrb, in_mat_dina, in_mat_dinb}, 128'(0));
        check("reset_w_ports", {w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web,
              w_mat_wr_addra, w_mat_wr_addrb, w_mat_dina, w_mat_dinb}, 128'(0));
        check("reset_ctrl", {a_ready, w_ready, busy, write_phase_done}, 128'(0));
        rst_n = 1'b1;
        step();

        do_load(1'b0, 1'b0, lat);
        check("latency_first", 128'(lat), 128'(NA + NB + 2));
        do_load(1'b0, 1'b0, lat);
        check("latency_restart_from_done", 128'(lat), 128'(NA + NB + 2));
        do_load(1'b1, 1'b0, lat);
        do_load(1'b0, 1'b1, lat);
        check("latency_start_ignored", 128'(lat), 128'(NA + NB + 2));

        // abort partway through the input-matrix load
        gaps = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 50 && ma < 5; i++) step();
        check("abort_reached_5_words", 128'(ma), 128'(5));
        rst_n = 1'b0; a_valid = 1'b0; w_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ports", {in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web,
              in_mat_wr_addra, in_mat_wr_addrb, in_mat_dina, in_mat_dinb}, 128'(0));
        check("abort_w_ports", {w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web,
              w_mat_wr_addra, w_mat_wr_addrb, w_mat_dina, w_mat_dinb}, 128'(0));
        check("abort_ctrl", {a_ready, w_ready, busy, write_phase_done}, 128'(0));
        #1 rst_n = 1'b1;
        step();
        do_load(1'b0, 1'b0, lat);
        check("latency_after_abort", 128'(lat), 128'(NA + NB + 2));

        // single-word input matrix build
        u1_a_valid = 1'b1; u1_a_data = 16'h0055;
        u1_w_valid = 1'b1; u1_w_data = 32'h0000_0077;
        u1_load_start = 1'b1;
        step();
        u1_load_start = 1'b0;
        step();
        @(negedge clk);
        check("one_word_in_en", {u1_in_ena, u1_in_wea, u1_in_enb, u1_in_web}, 128'(4'b1100));
        check("one_word_in_addr_data", {u1_in_addra, u1_in_dina}, {108'(0), 4'd0, 16'h0055});
        check("one_word_switch", {u1_a_ready, u1_w_ready}, 128'(2'b01));
        step();
        step();
        @(negedge clk);
        check("one_word_w_en", {u1_w_ena, u1_w_wea, u1_w_enb, u1_w_web}, 128'(4'b1111));
        check("one_word_w_addr", {u1_w_addra, u1_w_addrb}, 128'(8'h01));
        check("one_word_w_data", {u1_w_dina, u1_w_dinb}, {64'(0), 32'h77, 32'h77});
        check("one_word_flush_busy", {u1_busy, u1_done}, 128'(2'b10));
        step();
        @(negedge clk);
        check("one_word_done", {u1_busy, u1_done}, 128'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_load_sequencer.md
# bram_load_sequencer

Sequences the fill of the linear-projection input-matrix BRAM and weight-matrix BRAM from two ready/valid word streams. It drives both true-dual-port write ports of each memory, pairing consecutive words so two addresses are written per cycle. It then signals the read phase to downstream compute. It replaces the manual port toggling used during bring-up and sits between the host/DMA stream and the dual-port BRAMs.

## Interface
- DATA_WIDTH_A, 16: input-matrix word width (WIDTH_A*CHUNK_SIZE*NUM_CORES_A)
- DATA_WIDTH_B, 32: weight word width (WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES)
- ADDR_WIDTH_A, 4: input BRAM address width
- ADDR_WIDTH_B, 4: weight BRAM address width
- NUM_A_WORDS, 9: words to load into input BRAM (1..2**ADDR_WIDTH_A)
- NUM_B_WORDS, 12: words to load into weight BRAM (1..2**ADDR_WIDTH_B)
- clk  in  1  single clock
- rst_n  in  1  synchronous reset, active-low
- load_start  in  1  one-cycle pulse; begins a load when IDLE or DONE
- a_valid / a_ready / a_data  in/out/in  1/1/DATA_WIDTH_A  input-matrix stream
- w_valid / w_ready / w_data  in/out/in  1/1/DATA_WIDTH_B  weight stream
- in_mat_ena, in_mat_wea, in_mat_wr_addra, in_mat_dina  out  1/1/ADDR_WIDTH_A/DATA_WIDTH_A  input BRAM port A
- in_mat_enb, in_mat_web, in_mat_wr_addrb, in_mat_dinb  out  same widths  input BRAM port B
- w_mat_ena, w_mat_wea, w_mat_wr_addra, w_mat_dina  out  1/1/ADDR_WIDTH_B/DATA_WIDTH_B  weight BRAM port A
- w_mat_enb, w_mat_web, w_mat_wr_addrb, w_mat_dinb  out  same widths  weight BRAM port B
- write_phase_done  out  1  one-cycle pulse after the final weight write
- busy  out  1  high in LOAD_IN, LOAD_W, FLUSH

## Operation
- States: IDLE, LOAD_IN, LOAD_W, FLUSH, DONE.
- IDLE/DONE + load_start -> LOAD_IN. Clear word counter, pair register and pending flag.
- LOAD_IN: a_ready=1 and w_ready=0. Each accepted word increments cnt (0..NUM_A_WORDS-1).
  - Even cnt: store the word in the hold register and set pending.
  - Odd cnt: register a dual write. Port A gets addr cnt-1 with the held data. Port B gets addr cnt with the current data. Clear pending.
- If NUM_A_WORDS is odd, the last (even-index) word is written alone on port A. Port B en/we stay 0 that cycle.
- After the last A word is accepted: cnt resets to 0 and the state moves to LOAD_W. LOAD_W is identical, using the w_* stream and the w_mat ports.
- After the last B word is accepted: go to FLUSH for exactly one cycle, in which the last registered write is presented. Then go to DONE with write_phase_done=1 for one cycle.
- DONE holds all ports idle. A new load_start restarts the full sequence. load_start during busy is ignored.
- Addresses are never wrapped. cnt saturates at NUM_*_WORDS-1 by construction.
- ena equals wea, and enb equals web. Ports are enabled only on cycles they write.

## Timing
- Reset (rst_n=0 at a clk edge) values: state IDLE; all en/we 0; all addr and din 0; a_ready, w_ready, busy and write_phase_done 0; pending 0.
- Reset mid-load aborts immediately. Partially written BRAM contents are undefined, and no further writes occur.
- Write latency: a write is on the ports the cycle after the handshake that completes the pair, or completes an odd tail. Each port asserts for one cycle.
- A stalls are allowed anywhere (valid low). The hold register keeps its value and no write is issued.
- Stream switch: a_ready drops in the cycle after the last A handshake, and w_ready rises in that same cycle. The final A write and the first W acceptance may overlap in one cycle.
- write_phase_done is asserted exactly 2 cycles after the final w handshake (FLUSH, then DONE).
- Throughput: one word per cycle per stream when valid is held high. NUM_A_WORDS=9 at full rate loads A in 9 cycles.

## Test plan
- Defaults, continuous valid, a_data=i, w_data=100+i.
  - Input BRAM writes: pairs (0,1)…(6,7), then a port-A-only write at addr 8 with data 8 and enb=0.
  - Weight BRAM: 6 dual writes, last pair (10,11) with data 110/111.
  - write_phase_done exactly 2 cycles after w handshake #12.
- Random valid gaps on both streams: same address/data sequence as above, with no write during a gap and no lost or duplicated words.
- NUM_A_WORDS=1: single port-A write at addr 0. LOAD_W then starts the next cycle.
- rst_n low for one cycle after 5 A words: all outputs 0 the next cycle, state IDLE. load_start then reloads from addr 0.
- load_start pulsed during LOAD_W: ignored, and the sequence completes unchanged.
- Second load_start from DONE: full sequence repeats with identical timing.
